sync_fifo_v2: RTL
=================

# sync_fifo_v2

Parametrised synchronous FIFO that replaces the fixed-depth buffer used between the DRAM-cache request/response stages. It adds non-power-of-two depth, exact occupancy count, runtime-programmable almost-full/almost-empty thresholds, correct simultaneous read/write, sticky overflow/underflow error flags and a selectable show-ahead or registered read port. It sits on every queue between the tag-lookup, DRAM command and fill/response paths.

## Interface
- DATA_WIDTH, 8: bits per entry.
- DEPTH, 8: number of entries; any integer >= 2, not limited to powers of two.
- SHOW_AHEAD, 1: 1 = first-word-fall-through read port; 0 = registered read port.
- CNT_W, derived: $clog2(DEPTH+1); width of the count and threshold ports.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_en  in  1  write request.
- write_data  in  DATA_WIDTH  write payload.
- full  out  1  count == DEPTH.
- A_full  out  1  count >= a_full_thr.
- read_en  in  1  read request.
- read_data  out  DATA_WIDTH  head entry (mode 1) or last popped entry (mode 0).
- read_valid  out  1  mode 1: !empty; mode 0: read_data updated this cycle.
- empty  out  1  count == 0.
- A_empty  out  1  count <= a_empty_thr.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- a_full_thr  in  CNT_W  almost-full threshold, sampled combinationally.
- a_empty_thr  in  CNT_W  almost-empty threshold, sampled combinationally.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  clears overflow and underflow.

## Operation
- Write accepted (wa) = write_en && !full. Read accepted (ra) = read_en && !empty. No write pass-through when full, even with a concurrent read.
- wa: mem[head] <= write_data; head advances. ra: tail advances.
- Pointers wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
- count update: wa&&!ra -> +1; ra&&!wa -> -1; both or neither -> unchanged. count never leaves 0..DEPTH.
- full, empty, A_full, A_empty are combinational from the registered count and the threshold inputs. A threshold change takes effect in the same cycle.
- overflow is set on the edge after write_en && full. underflow is set on the edge after read_en && empty. Both bits hold until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- SHOW_AHEAD=1: read_data = mem[tail] combinationally. It is undefined while empty.
- SHOW_AHEAD=0: on ra, read_data <= mem[tail], and read_valid = 1 for exactly the following cycle. Otherwise read_valid = 0 and read_data holds its value.
- Storage array is not reset; only control state is.

## Timing
- Reset (asynchronous assert, synchronous-safe release) clears the following immediately, without waiting for clk:
  - head, tail, count = 0; empty = 1; full = 0; A_empty = 1.
  - A_full = (a_full_thr == 0).
  - overflow = underflow = 0; read_valid = 0.
  - SHOW_AHEAD=0 read_data = 0.
- Reset mid-operation discards all entries. Its first cycle after release behaves as a fresh FIFO.
- Write-to-read latency:
  - mode 1: an entry written at edge N is visible on read_data and !empty after edge N.
  - mode 0: a read accepted at edge N+1 produces data after edge N+1, with read_valid high for that cycle.
- Flags and count change only on clk edges (or reset), apart from the threshold inputs' combinational effect.
- Throughput: one write and one read per cycle sustained, at any occupancy 1..DEPTH-1.

## Test plan
- DEPTH=5, SHOW_AHEAD=1: write 0x11..0x15 -> full=1, count=5. Then write 0x16 -> dropped, overflow=1 next cycle. Read 5 -> 0x11..0x15 in order across the wrap, empty=1.
- DEPTH=5: prefill 3, then assert write_en and read_en together for 10 cycles -> count stays 3, data in order, pointers wrap twice.
- Empty FIFO, read_en=1 -> count stays 0, underflow=1. Hold err_clr=1 with another read_en on empty -> underflow stays 1. err_clr alone -> 0.
- a_full_thr=4, a_empty_thr=1: fill 0->5 -> A_empty drops at count=2, A_full rises at count=4. Change a_full_thr to 6 at count=5 -> A_full=0 in the same cycle.
- SHOW_AHEAD=0: write 0xA5, then read -> read_valid=1 and read_data=0xA5 for one cycle. read_data then holds 0xA5 with read_valid=0.
- With 3 entries, assert reset low between edges -> count=0, empty=1 and overflow=0 before the next edge. After release, write 0x77 and read it back -> 0x77.

Source files
------------

// File: rtl/sync_fifo_v2.sv
// Parametrised synchronous FIFO: arbitrary depth, exact occupancy, programmable
// almost-full/almost-empty thresholds, sticky error flags, show-ahead or
// registered read port.
module sync_fifo_v2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SHOW_AHEAD = 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  full,
  output logic                  A_full,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  empty,
  output logic                  A_empty,
  output logic [CNT_W-1:0]      count,
  input  logic [CNT_W-1:0]      a_full_thr,
  input  logic [CNT_W-1:0]      a_empty_thr,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  wa;
  logic                  ra;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags decoded from the registered count and live thresholds.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign A_full  = (count >= a_full_thr);
  assign A_empty = (count <= a_empty_thr);

  // Accepted operations; a full FIFO never accepts a write, even with a read.
  assign wa = write_en && !full;
  assign ra = read_en && !empty;

  // Storage array, intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wa) mem[head] <= write_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wa) head <= ptr_inc(head);
      if (ra) tail <= ptr_inc(tail);
      unique case ({wa, ra})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full) overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (read_en && empty) underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      // Head entry falls through to the read port.
      assign read_data  = mem[tail];
      assign read_valid = !empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  rv_q;

      // Popped entry is registered; valid pulses for the cycle after a pop.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rv_q <= ra;
          if (ra) rd_q <= mem[tail];
        end
      end

      assign read_data  = rd_q;
      assign read_valid = rv_q;
    end
  endgenerate

endmodule
